vm2_dma_arb: RTL and testbench

Q-bus DMA arbiter for the 1801VM2 system. It shares the processor bus among up to four local DMA masters using round-robin priority. It runs the vm2 DMR/DMGO/SACK bus-grant handshake on their behalf, and raises a one-hot grant only once the bus is idle. It sits beside the `vm2` instance in the board top, between the CPU grant pins and the DMA peripherals.

---
 rtl/vm2_pkg.sv | 18 +
 rtl/vm2_rr_pick.sv | 32 +++
 rtl/vm2_dma_arb.sv | 100 ++++++++++
 tb/tb_vm2_dma_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm2_pkg.sv
// rtl/vm2_pkg.sv - shared state encoding and sizing helpers for the vm2 DMA arbiter
package vm2_pkg;

    localparam int NREQ_MAX = 4;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_ACK,
        ARB_OWN,
        ARB_REL
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vm2_rr_pick.sv
// rtl/vm2_rr_pick.sv - combinational round-robin picker, searches from last+1 modulo NREQ
module vm2_rr_pick
    import vm2_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   widx
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        win     = '0;
        widx    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(last) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                win[w_idx] = 1'b1;
                widx       = w_idx;
            end
        end
    end

endmodule

// File: rtl/vm2_dma_arb.sv
// rtl/vm2_dma_arb.sv - Q-bus DMA arbiter: DMR/DMGO/SACK handshake and round-robin one-hot grant
module vm2_dma_arb
    import vm2_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int MAXOWN = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            tout,
    output logic            dmr_n,
    input  logic            dmgo_n,
    output logic            sack_n,
    input  logic            sync_n,
    input  logic            rply_n
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = (MAXOWN > 0) ? $clog2(MAXOWN + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXOWN);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_widx;
    logic [IW-1:0]   w_widx;
    logic [NREQ-1:0] w_win;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_idle_bus;
    logic            w_hit;
    logic            w_forced;

    vm2_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req),
        .last (r_last),
        .win  (w_win),
        .widx (w_widx)
    );

    assign w_idle_bus = sync_n & rply_n;
    assign w_cnt_inc  = r_cnt + CW'(1);
    // A zero limit disables forced release entirely.
    assign w_hit      = (MAXOWN != 0) && (w_cnt_inc == CNT_MAX);

    always_comb begin
        w_next   = r_state;
        w_forced = 1'b0;
        case (r_state)
            ARB_IDLE: if (|req && dmgo_n) w_next = ARB_REQ;
            ARB_REQ:  if (!dmgo_n) w_next = ARB_ACK;
            ARB_ACK:  if (w_idle_bus) w_next = (|req) ? ARB_OWN : ARB_REL;
            ARB_OWN: begin
                if (!req[r_widx]) begin
                    w_next = ARB_REL;
                end else if (w_hit) begin
                    w_next   = ARB_REL;
                    w_forced = 1'b1;
                end
            end
            ARB_REL:  w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_last  <= IW'(NREQ - 1);
            r_widx  <= '0;
            r_cnt   <= '0;
            gnt     <= '0;
            tout    <= 1'b0;
            dmr_n   <= 1'b1;
            sack_n  <= 1'b1;
        end else begin
            r_state <= w_next;
            dmr_n   <= (w_next != ARB_REQ);
            sack_n  <= !(w_next inside {ARB_ACK, ARB_OWN, ARB_REL});
            tout    <= w_forced;
            if (r_state == ARB_ACK && w_next == ARB_OWN) begin
                r_last <= w_widx;
                r_widx <= w_widx;
                gnt    <= w_win;
                r_cnt  <= '0;
            end else if (w_next == ARB_OWN) begin
                r_cnt  <= w_cnt_inc;
            end else begin
                gnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vm2_dma_arb.sv
// tb/tb_vm2_dma_arb.sv - directed self-checking bench for vm2_dma_arb
module tb_vm2_dma_arb;

    localparam int NREQ   = 4;
    localparam int MAXOWN = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            tout;
    logic            dmr_n;
    logic            dmgo_n;
    logic            sack_n;
    logic            sync_n;
    logic            rply_n;

    int checks = 0;
    int errors = 0;
    int cpu_late = 0;
    int c_cnt = 0;
    int c_seen = 0;
    int f_stale, f_falls;
    logic f_pdmr, f_pdmgo;

    vm2_dma_arb #(
        .NREQ   (NREQ),
        .MAXOWN (MAXOWN)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .tout   (tout),
        .dmr_n  (dmr_n),
        .dmgo_n (dmgo_n),
        .sack_n (sack_n),
        .sync_n (sync_n),
        .rply_n (rply_n)
    );

    always #5 clk = ~clk;

    // CPU model: grants on the third falling edge that sees DMR low; releases DMGO
    // on SACK, or cpu_late cycles after SACK has gone high again.
    initial begin
        dmgo_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dmgo_n = 1'b1;
                c_cnt  = 0;
                c_seen = 0;
            end else if (dmgo_n) begin
                c_cnt = dmr_n ? 0 : c_cnt + 1;
                if (c_cnt >= 3) begin
                    dmgo_n = 1'b0;
                    c_cnt  = 0;
                    c_seen = 0;
                end
            end else begin
                if (!sack_n) c_seen = 1;
                if (c_seen != 0 && (cpu_late == 0 || sack_n)) begin
                    if (c_cnt >= cpu_late) dmgo_n = 1'b1;
                    else c_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        req      = '0;
        sync_n   = 1'b1;
        rply_n   = 1'b1;
        cpu_late = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic fair_tick();
        step();
        if (f_pdmr && !dmr_n && !f_pdmgo) f_stale++;
        if (f_pdmr && !dmr_n) f_falls++;
        f_pdmr  = dmr_n;
        f_pdmgo = dmgo_n;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = '0;
        sync_n = 1'b1;
        rply_n = 1'b1;
        step();
        checks++; if (dmr_n !== 1'b1) begin errors++; $display("FAIL reset_dmr_n: got %b expected 1", dmr_n); end
        checks++; if (sack_n !== 1'b1) begin errors++; $display("FAIL reset_sack_n: got %b expected 1", sack_n); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (tout !== 1'b0) begin errors++; $display("FAIL reset_tout: got %b expected 0", tout); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                checks++;
                if (dmr_n !== 1'b0) begin errors++; $display("FAIL single_dmr_c1: got %b expected 0", dmr_n); end
            end
            if (c == 4) begin
                checks++;
                if ({sack_n, dmr_n} !== 2'b01) begin errors++; $display("FAIL single_sack_c4: got sack_n,dmr_n=%b expected 01", {sack_n, dmr_n}); end
                checks++;
                if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_c4: got %b expected 0000", gnt); end
            end
            if (c == 5) begin
                checks++;
                if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_c5: got %b expected 0001", gnt); end
            end
        end
        step();
        step();
        req = 4'b0000;
        step();
        checks++;
        if ({gnt, sack_n} !== 5'b00000) begin errors++; $display("FAIL single_release_k1: got gnt,sack_n=%b expected 00000", {gnt, sack_n}); end
        step();
        checks++;
        if ({gnt, sack_n} !== 5'b00001) begin errors++; $display("FAIL single_release_k2: got gnt,sack_n=%b expected 00001", {gnt, sack_n}); end
    endtask

    task automatic test_fairness();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int budget;
        logic [NREQ-1:0] exp_gnt;
        apply_reset();
        cpu_late = 3;
        f_stale  = 0;
        f_falls  = 0;
        f_pdmr   = dmr_n;
        f_pdmgo  = dmgo_n;
        req      = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            budget = 0;
            while (gnt == '0 && budget < 60) begin
                fair_tick();
                budget++;
            end
            exp_gnt = 4'(1 << exp_order[i]);
            checks++;
            if (gnt !== exp_gnt) begin errors++; $display("FAIL fair_order_%0d: got %b expected %b", i, gnt, exp_gnt); end
            repeat (7) fair_tick();
            req[exp_order[i]] = 1'b0;
            fair_tick();
            req[exp_order[i]] = 1'b1;
        end
        req = '0;
        repeat (12) fair_tick();
        checks++;
        if (f_stale !== 0) begin errors++; $display("FAIL fair_stale_dmr: got %0d expected 0", f_stale); end
        checks++;
        if (f_falls !== 5) begin errors++; $display("FAIL fair_dmr_count: got %0d expected 5", f_falls); end
    endtask

    task automatic test_busy_bus();
        apply_reset();
        sync_n = 1'b0;
        req    = 4'b0001;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c >= 4 && c <= 13) begin
                checks++;
                if ({sack_n, gnt} !== 5'b00000) begin errors++; $display("FAIL busy_hold_c%0d: got sack_n,gnt=%b expected 00000", c, {sack_n, gnt}); end
            end
            if (c == 13) sync_n = 1'b1;
            if (c == 14) begin
                checks++;
                if (gnt !== 4'b0001) begin errors++; $display("FAIL busy_gnt_c14: got %b expected 0001", gnt); end
            end
        end
        req = '0;
        repeat (3) step();
    endtask

    task automatic test_withdrawn();
        logic [8:1] exp_dmr;
        logic [8:1] exp_sack;
        exp_dmr  = 8'b11111000;
        exp_sack = 8'b11100111;
        apply_reset();
        req = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) req = 4'b0000;
            checks++;
            if ({dmr_n, sack_n, gnt} !== {exp_dmr[c], exp_sack[c], 4'b0000})
                begin errors++; $display("FAIL withdraw_c%0d: got dmr_n,sack_n,gnt=%b expected %b", c, {dmr_n, sack_n, gnt}, {exp_dmr[c], exp_sack[c], 4'b0000}); end
        end
    endtask

    task automatic test_forced_release();
        int g2 = 0, tcnt = 0, tcyc = -1, g3cyc = -1, g2b = -1;
        apply_reset();
        req = 4'b0100;
        for (int c = 1; c <= 45; c++) begin
            step();
            if (gnt == 4'b0100 && c < 27) g2++;
            if (tout) begin tcnt++; tcyc = c; end
            if (gnt == 4'b1000 && g3cyc < 0) begin g3cyc = c; req = 4'b0100; end
            if (c > 28 && gnt == 4'b0100 && g2b < 0) g2b = c;
            if (c == 22) req = 4'b1100;
        end
        req = '0;
        repeat (3) step();
        checks++; if (g2 !== 16) begin errors++; $display("FAIL forced_gnt_cycles: got %0d expected 16", g2); end
        checks++; if (tcnt !== 1) begin errors++; $display("FAIL forced_tout_pulses: got %0d expected 1", tcnt); end
        checks++; if (tcyc !== 21) begin errors++; $display("FAIL forced_tout_cycle: got %0d expected 21", tcyc); end
        checks++; if (g3cyc !== 27) begin errors++; $display("FAIL forced_lowprio_gnt3: got %0d expected 27", g3cyc); end
        checks++; if (g2b !== 34) begin errors++; $display("FAIL forced_regrant: got %0d expected 34", g2b); end
    endtask

    task automatic test_async_reset();
        int budget = 0;
        apply_reset();
        req = 4'b0001;
        while (gnt == '0 && budget < 20) begin
            step();
            budget++;
        end
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL async_pre_gnt: got %b expected 0001", gnt); end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, sack_n, dmr_n, tout} !== 7'b0000110)
            begin errors++; $display("FAIL async_release: got gnt,sack_n,dmr_n,tout=%b expected 0000110", {gnt, sack_n, dmr_n, tout}); end
        req = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        sync_n = 1'b1;
        rply_n = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_busy_bus();
        test_withdrawn();
        test_forced_release();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
